imem_loader: RTL and testbench

- Writer side of the instruction memory: streams a program image into the byte-addressed imem storage and holds the single-cycle CPU until the image is in place.
- Replaces bench-time file preloading with an in-system boot path.
- Sits between a byte-stream source (UART/debug bridge or bench driver) and the imem byte write port; drives the CPU run-enable.

---
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed program image into imem and holds the CPU until it is loaded.
// Optional trailing XOR checksum of the data bytes is built in with IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_count
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR} state_t;
  localparam state_t FINISH = CSUM;
  logic [7:0] csum_q, csum_d;
`else
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERROR} state_t;
  localparam state_t FINISH = DONE;
`endif
  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W:0]   byte_count_q, byte_count_d;
  logic              acc;
  logic [15:0]       new_len;
  logic [31:0]       end_addr;
  logic              last_byte;
  assign acc       = in_valid & in_ready_q;
  assign new_len   = {len_hi_q, in_data};
  // image end computed wide so a large N can never wrap past the capacity check
  assign end_addr  = 32'(BASE_ADDR) + {14'd0, new_len, 2'b00};
  assign last_byte = 32'(byte_count_q) + 32'd1 == {14'd0, len_q, 2'b00};
  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    len_d        = len_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    byte_count_d = byte_count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: if (start) begin
        state_d      = LEN_HI;
        byte_count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d       = '0;
`endif
      end
      LEN_HI: if (acc) begin
        len_hi_d = in_data;
        state_d  = LEN_LO;
      end
      LEN_LO: if (acc) begin
        len_d   = new_len;
        state_d = new_len == 16'd0 ? FINISH : end_addr > 32'(MEM_BYTES) ? ERROR : DATA;
      end
      DATA: if (acc) begin
        mem_we_d     = 1'b1;
        mem_addr_d   = ADDR_W'(BASE_ADDR) + byte_count_q[ADDR_W-1:0];
        mem_wdata_d  = in_data;
        byte_count_d = byte_count_q == (ADDR_W+1)'(MEM_BYTES) ? byte_count_q : byte_count_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d       = csum_q ^ in_data;
`endif
        state_d      = last_byte ? FINISH : DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: if (acc) state_d = in_data == csum_q ? DONE : ERROR;
`endif
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == LEN_HI || state_d == LEN_LO || state_d == DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
    in_ready_d = in_ready_d || state_d == CSUM;
`endif
    done_d     = state_d == DONE;
    error_d    = state_d == ERROR;
    cpu_hold_d = state_d != DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_hi_q     <= '0;
      len_q        <= '0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      byte_count_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
      byte_count_q <= byte_count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end
  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign byte_count = byte_count_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader; records every write seen on the imem port.
module tb_imem_loader;
  logic        clk = 0;
  logic        rst_n, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, cpu_hold, done, error;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [10:0] byte_count;
  int          total = 0, bad = 0, nwr = 0, base;
  logic [9:0]  wa [256];
  logic [7:0]  wd [256];
  logic [7:0]  img [16];

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we && nwr < 256) begin
    wa[nwr] <= mem_addr;
    wd[nwr] <= mem_wdata;
    nwr     <= nwr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic load(input int n, input bit gaps);
    logic [7:0] x = 0;
    pulse_start();
    send(8'(n >> 8));
    send(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      send(img[i]);
      x ^= img[i];
      if (gaps) begin
        start = i == 1;
        @(negedge clk);
        start = 0;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(x);
`endif
  endtask

  task automatic chk_writes(input string tag, input int first, input int n);
    chk({tag, "_nwr"}, 32'(nwr - first), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, 32'(wa[first+i]), 32'(i));
      chk({tag, "_data"}, 32'(wd[first+i]), 32'(img[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; start = 0; in_valid = 0; in_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_hold", 32'(cpu_hold), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_count", 32'(byte_count), 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_hold", 32'(cpu_hold), 1);
    // basic: three addi words (s1=3, t0=255, t1=-3)
    img = '{8'h20, 8'h11, 8'h00, 8'h03, 8'h20, 8'h08, 8'h00, 8'hFF,
            8'h20, 8'h09, 8'hFF, 8'hFD, 8'h00, 8'h00, 8'h00, 8'h00};
    base = nwr;
    load(3, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk("done_with_last_we", {30'd0, done, mem_we}, 3);
`endif
    @(negedge clk);
    chk("basic_we_pulse", 32'(mem_we), 0);
    chk_writes("basic", base, 12);
    chk("basic_done", 32'(done), 1);
    chk("basic_hold", 32'(cpu_hold), 0);
    chk("basic_count", 32'(byte_count), 12);
    chk("basic_ready", 32'(in_ready), 0);
    // backpressure with an ignored start in DATA
    img[0:3] = '{8'h8C, 8'h10, 8'h00, 8'h04};
    base = nwr;
    load(1, 1);
    @(negedge clk);
    chk_writes("bp", base, 4);
    chk("bp_done", 32'(done), 1);
    chk("bp_count", 32'(byte_count), 4);
    // zero length
    base = nwr;
    load(0, 0);
    for (int i = 0; i < 4 && !done; i++) @(negedge clk);
    chk("zero_done", 32'(done), 1);
    chk("zero_hold", 32'(cpu_hold), 0);
    chk("zero_nwr", 32'(nwr - base), 0);
    chk("zero_count", 32'(byte_count), 0);
    // oversize: 257 words do not fit in 1024 bytes
    base = nwr;
    pulse_start();
    chk("restart_done_clr", 32'(done), 0);
    send(8'h01);
    send(8'h01);
    @(negedge clk);
    chk("big_error", 32'(error), 1);
    chk("big_hold", 32'(cpu_hold), 1);
    chk("big_ready", 32'(in_ready), 0);
    chk("big_done", 32'(done), 0);
    chk("big_nwr", 32'(nwr - base), 0);
    img[0:3] = '{8'h24, 8'h0A, 8'h00, 8'h05};
    base = nwr;
    load(1, 0);
    @(negedge clk);
    chk("recover_error", 32'(error), 0);
    chk("recover_done", 32'(done), 1);
    chk_writes("recover", base, 4);
    // reset after five data bytes of a two-word image
    img[0:7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    pulse_start();
    send(8'h00);
    send(8'h02);
    for (int i = 0; i < 5; i++) send(img[i]);
    chk("mid_count", 32'(byte_count), 5);
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_we", 32'(mem_we), 0);
    chk("mid_rst_count", 32'(byte_count), 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    chk("mid_rst_hold", 32'(cpu_hold), 1);
    rst_n = 1;
    @(negedge clk);
    base = nwr;
    load(1, 0);
    @(negedge clk);
    chk("after_rst_done", 32'(done), 1);
    chk("after_rst_count", 32'(byte_count), 4);
    chk_writes("after_rst", base, 4);
`ifdef IMEM_LOADER_CHECKSUM_EN
    img[0:3] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load(1, 0);
    @(negedge clk);
    chk("csum_ok_done", 32'(done), 1);
    pulse_start();
    send(8'h00);
    send(8'h01);
    for (int i = 0; i < 4; i++) send(img[i]);
    send(8'h01);
    @(negedge clk);
    chk("csum_bad_error", 32'(error), 1);
    chk("csum_bad_hold", 32'(cpu_hold), 1);
    chk("csum_bad_done", 32'(done), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
